// File: rtl/ir_prefetch_queue.sv
// ir_prefetch_queue: instruction register fed by a DEPTH-entry prefetch FIFO.
// Memory pushes words through a valid/ready handshake; the controller's IR_Ld
// pops the oldest word into the instruction register. The register is exposed
// whole and as opcode/operand fields. Flush clears FIFO and IR for a branch.
module ir_prefetch_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int OP_W  = 4
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       Flush,
  input  logic                       In_Valid,
  input  logic [WIDTH-1:0]           In_Data,
  output logic                       In_Ready,
  input  logic                       IR_Ld,
  output logic [WIDTH-1:0]           IRout,
  output logic                       IR_Valid,
  output logic [OP_W-1:0]            Opcode,
  output logic [WIDTH-OP_W-1:0]      Operand,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Empty,
  output logic                       Full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Prefetch storage; holds data only, so it carries no reset.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0] count_q, count_nxt;
  logic [WIDTH-1:0] ir_q, ir_nxt;
  logic ir_vld_q, ir_vld_nxt;

  logic push, pop;

  // Status flags come only from the registered count, so In_Ready never
  // combinationally depends on In_Valid or IR_Ld.
  assign Empty    = (count_q == '0);
  assign Full     = (count_q == FULL_CNT);
  assign In_Ready = ~Full;
  assign Count    = count_q;

  // A flush overrides both handshakes in the same cycle.
  assign push = In_Valid & In_Ready & ~Flush;
  assign pop  = IR_Ld & ~Empty & ~Flush;

  // Pointer and occupancy next state. DEPTH is a power of two, so the natural
  // AW-bit rollover gives the modulo-DEPTH wrap.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count_q;
    if (Flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + PTR_ONE;
      if (pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count_nxt = count_q + CNT_ONE;
        2'b01:   count_nxt = count_q - CNT_ONE;
        default: count_nxt = count_q;
      endcase
    end
  end

  // Instruction register next state: a load from an empty FIFO is a bubble
  // that keeps the old word but marks it as no longer valid.
  always_comb begin
    ir_nxt     = ir_q;
    ir_vld_nxt = ir_vld_q;
    if (Flush) begin
      ir_nxt     = '0;
      ir_vld_nxt = 1'b0;
    end else if (IR_Ld) begin
      if (pop) begin
        ir_nxt     = mem[rd_ptr];
        ir_vld_nxt = 1'b1;
      end else begin
        ir_vld_nxt = 1'b0;
      end
    end
  end

  // FIFO control state; reset drops all entries immediately.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_nxt;
    end
  end

  // Architectural instruction register and its valid flag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ir_q     <= '0;
      ir_vld_q <= 1'b0;
    end else begin
      ir_q     <= ir_nxt;
      ir_vld_q <= ir_vld_nxt;
    end
  end

  // Storage write on an accepted push.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= In_Data;
  end

  assign IRout    = ir_q;
  assign IR_Valid = ir_vld_q;
  assign Opcode   = ir_q[WIDTH-1 -: OP_W];
  assign Operand  = ir_q[WIDTH-OP_W-1:0];

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Bench for ir_prefetch_queue: directed scenarios followed by random traffic,
// all checked against a queue-based behavioural model.
module tb_ir_prefetch_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int OP_W  = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             Flush;
  logic             In_Valid;
  logic [WIDTH-1:0] In_Data;
  logic             In_Ready;
  logic             IR_Ld;
  logic [WIDTH-1:0] IRout;
  logic             IR_Valid;
  logic [OP_W-1:0]  Opcode;
  logic [WIDTH-OP_W-1:0] Operand;
  logic [CW-1:0]    Count;
  logic             Empty;
  logic             Full;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_ir;
  logic             m_irv;

  ir_prefetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Flush(Flush), .In_Valid(In_Valid),
    .In_Data(In_Data), .In_Ready(In_Ready), .IR_Ld(IR_Ld), .IRout(IRout),
    .IR_Valid(IR_Valid), .Opcode(Opcode), .Operand(Operand), .Count(Count),
    .Empty(Empty), .Full(Full)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ir  = '0;
    m_irv = 1'b0;
  endtask

  // One clock edge of the queue rules, using the inputs currently applied.
  task automatic model_edge();
    bit can_push;
    can_push = In_Valid && (mq.size() < DEPTH);
    if (Flush) begin
      model_reset();
    end else begin
      if (IR_Ld) begin
        if (mq.size() > 0) begin
          m_ir  = mq.pop_front();
          m_irv = 1'b1;
        end else begin
          m_irv = 1'b0;
        end
      end
      if (can_push) mq.push_back(In_Data);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(Count), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(Empty), 32'(mq.size() == 0));
    chk({tag, ".full"},  32'(Full),  32'(mq.size() == DEPTH));
    chk({tag, ".ready"}, 32'(In_Ready), 32'(mq.size() != DEPTH));
    chk({tag, ".ir"},    32'(IRout), 32'(m_ir));
    chk({tag, ".irv"},   32'(IR_Valid), 32'(m_irv));
    chk({tag, ".op"},    32'(Opcode), 32'(m_ir >> (WIDTH-OP_W)));
    chk({tag, ".opd"},   32'(Operand), 32'(m_ir % (1 << (WIDTH-OP_W))));
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d,
                       input logic ld, input logic fl);
    In_Valid = v;
    In_Data  = d;
    IR_Ld    = ld;
    Flush    = fl;
  endtask

  task automatic step(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    Reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_all("reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    // 1: push then load
    drive(1'b1, 16'h1234, 1'b0, 1'b0); step("t1_push");
    drive(1'b0, '0, 1'b1, 1'b0);        step("t1_ld");
    chk("t1_ir", 32'(IRout), 32'h1234);
    chk("t1_op", 32'(Opcode), 32'h1);
    chk("t1_opd", 32'(Operand), 32'h234);
    chk("t1_irv", 32'(IR_Valid), 32'h1);
    chk("t1_empty", 32'(Empty), 32'h1);

    // 2: fill, hold off fifth word, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'hA001 + WIDTH'(i), 1'b0, 1'b0); step("t2_fill");
    end
    chk("t2_count", 32'(Count), 32'd4);
    chk("t2_full", 32'(Full), 32'h1);
    chk("t2_ready", 32'(In_Ready), 32'h0);
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0); step("t2_hold");
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0); step("t2_hold");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0); step("t2_pop");
      chk("t2_seq", 32'(IRout), 32'hA001 + i);
    end
    chk("t2_empty", 32'(Empty), 32'h1);

    // 3: streaming across pointer wrap
    drive(1'b1, 16'h0000, 1'b0, 1'b0); step("t3_prime");
    for (int i = 1; i < 10; i++) begin
      drive(1'b1, WIDTH'(i), 1'b1, 1'b0); step("t3_stream");
      chk("t3_seq", 32'(IRout), 32'(i - 1));
      chk("t3_cnt", 32'(Count), 32'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0); step("t3_last");
    chk("t3_seq", 32'(IRout), 32'd9);

    // 4: bubble on empty
    drive(1'b1, 16'h5555, 1'b0, 1'b0); step("t4_push");
    drive(1'b0, '0, 1'b1, 1'b0);        step("t4_ld");
    drive(1'b0, '0, 1'b1, 1'b0);        step("t4_bubble");
    chk("t4_ir", 32'(IRout), 32'h5555);
    chk("t4_irv", 32'(IR_Valid), 32'h0);
    chk("t4_cnt", 32'(Count), 32'h0);

    // 5: flush wins over push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h7000 + WIDTH'(i), 1'b0, 1'b0); step("t5_fill");
    end
    drive(1'b1, 16'hCCCC, 1'b1, 1'b1); step("t5_flush");
    chk("t5_cnt", 32'(Count), 32'h0);
    chk("t5_ir", 32'(IRout), 32'h0);
    chk("t5_ready", 32'(In_Ready), 32'h1);
    drive(1'b0, '0, 1'b1, 1'b0); step("t5_after");
    chk("t5_irv", 32'(IR_Valid), 32'h0);

    // 6: asynchronous reset between edges
    drive(1'b1, 16'h1111, 1'b0, 1'b0); step("t6_fill");
    drive(1'b1, 16'h2222, 1'b1, 1'b0); step("t6_fill");
    drive(1'b1, 16'h3333, 1'b0, 1'b0); step("t6_fill");
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("t6_pre", 32'(Count), 32'd2);
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_rst");
    @(negedge Clk);
    Reset_n = 1'b1;
    step("t6_rel");
    chk("t6_empty", 32'(Empty), 32'h1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0));
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
